// File: rtl/scroll_sequencer_pkg.sv
// Shared types and constants for the scrolling seven-segment display sequencer.
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int MSG_DEPTH  = 16;
    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int ADDR_W     = $clog2(MSG_DEPTH);
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

    // Active-low one-hot digit enable for a scan position.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return ~onehot;
    endfunction

endpackage

// File: rtl/scroll_sequencer_tick_divider.sv
// Refresh-tick divider: free-running count 0..CLK_DIV-1, one-cycle tick on the
// last count. Runs in every controller state so the scan cadence never drifts.
module tick_divider #(
    parameter int CLK_DIV = 100000
) (
    input  logic CLK,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // wrap to zero after the terminal count, otherwise count up
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: message buffer, 8-digit multiplex scan and scroll-step
// control for the seven-segment display. Outputs drive the hex decode stage.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | display blanked; base, scan index and step count held at 0
// RUN   | scan advances each tick; base steps every SHIFT_TICKS ticks
// PAUSE | scan advances each tick; step count and base frozen
module scroll_sequencer
    import scroll_pkg::*;
#(
    parameter int CLK_DIV     = 100000,
    parameter int SHIFT_TICKS = 256
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    input  logic                  dir,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DIGIT_W-1:0]    wr_data,
    output logic [DIGIT_W-1:0]    digit_val,
    output logic [IDX_W-1:0]      digit_idx,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  shift_pulse,
    output logic [ADDR_W-1:0]     base,
    output logic [1:0]            state
);
    localparam int STEP_W = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SHIFT_TICKS - 1);

    state_t                state_q, state_d;
    logic                  tick;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [ADDR_W-1:0]     slot;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [DIGIT_W-1:0]    val_q, val_d;
    logic                  pulse_q, pulse_d;
    logic [DIGIT_W-1:0]    msg_q [MSG_DEPTH];

    tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLK  (CLK),
        .rst  (rst),
        .tick (tick)
    );

    // state register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: stop outranks start, start outranks hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (hold) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // next scan/window/display values; the read slot uses the post-edge index
    // and base so a tick and a step landing together show the new window at once
    always_comb begin
        idx_d   = idx_q;
        base_d  = base_q;
        step_d  = step_q;
        pulse_d = 1'b0;
        slot    = '0;
        anode_d = ANODE_OFF;
        val_d   = '0;
        case (state_q)
            RUN: begin
                if (tick) begin
                    idx_d = idx_q + 1'b1;
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        pulse_d = 1'b1;
                        base_d  = dir ? (base_q - 1'b1) : (base_q + 1'b1);
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (tick) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                idx_d  = '0;
                base_d = '0;
                step_d = '0;
            end
        endcase
        if (state_q != IDLE) begin
            slot    = base_d + ADDR_W'(idx_d);
            anode_d = anode_for(idx_d);
            // write-first: a same-edge write to the displayed slot is shown directly
            val_d   = (wr_en && (wr_addr == slot)) ? wr_data : msg_q[slot];
        end
    end

    // scan, window and display registers, updated together so anode and digit_val stay aligned
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            base_q  <= '0;
            step_q  <= '0;
            anode_q <= ANODE_OFF;
            val_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            base_q  <= base_d;
            step_q  <= step_d;
            anode_q <= anode_d;
            val_q   <= val_d;
            pulse_q <= pulse_d;
        end
    end

    // message buffer: writable in every state, cleared only by reset
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                msg_q[i] <= '0;
            end
        end else if (wr_en) begin
            msg_q[wr_addr] <= wr_data;
        end
    end

    assign digit_val   = val_q;
    assign digit_idx   = idx_q;
    assign anode       = anode_q;
    assign shift_pulse = pulse_q;
    assign base        = base_q;
    assign state       = state_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Scoreboard bench for scroll_sequencer (CLK_DIV=4, SHIFT_TICKS=2).
// Stimulus advances a behavioural model one clock at a time and queues the
// expected outputs; a negedge monitor pops and compares. Scroll steps are also
// queued separately and matched against every shift_pulse the DUT raises.
module tb_scroll_sequencer;
    localparam int CLK_DIV     = 4;
    localparam int SHIFT_TICKS = 2;

    logic       CLK, rst, start, stop, hold, dir, wr_en;
    logic [3:0] wr_addr, wr_data, digit_val, base;
    logic [2:0] digit_idx;
    logic [7:0] anode;
    logic       shift_pulse;
    logic [1:0] state;

    scroll_sequencer #(.CLK_DIV(CLK_DIV), .SHIFT_TICKS(SHIFT_TICKS)) dut (
        .CLK(CLK), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_val(digit_val), .digit_idx(digit_idx), .anode(anode),
        .shift_pulse(shift_pulse), .base(base), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         ph;
        logic [1:0] st;
        logic [3:0] bs;
        logic [2:0] ix;
        logic [7:0] an;
        logic [3:0] vl;
        logic       pl;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] pul_q[$];
    int         n_vec   = 0;
    int         n_bad   = 0;
    int         phase   = 0;
    bit         drain   = 0;
    bit         drained = 0;

    // reference model
    logic [1:0] m_st;
    int         m_cnt, m_idx, m_base, m_step;
    logic [7:0] m_an;
    logic [3:0] m_val;
    logic       m_pul;
    logic [3:0] mem [16];

    task automatic model_reset();
        m_st = 2'd0; m_cnt = 0; m_idx = 0; m_base = 0; m_step = 0;
        m_an = 8'hFF; m_val = 4'h0; m_pul = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        pul_q.delete();
    endtask

    task automatic push_exp();
        exp_t e;
        e.ph = phase; e.st = m_st; e.bs = 4'(m_base); e.ix = 3'(m_idx);
        e.an = m_an;  e.vl = m_val; e.pl = m_pul;
        exp_q.push_back(e);
    endtask

    // one clock edge: model sees the inputs as they stand before the edge
    task automatic clk1(input bit chk);
        bit         tk, sa, sp, hd, dr, we;
        logic [3:0] wa, wd;
        tk = (m_cnt == CLK_DIV - 1);
        sa = start; sp = stop; hd = hold; dr = dir; we = wr_en; wa = wr_addr; wd = wr_data;
        @(posedge CLK);
        #1;
        if (we) mem[wa] = wd;
        m_pul = 1'b0;
        if (m_st == 2'd0) begin
            m_idx = 0; m_base = 0; m_step = 0; m_an = 8'hFF; m_val = 4'h0;
        end else begin
            if (tk) begin
                m_idx = (m_idx + 1) % 8;
                if (m_st == 2'd1) begin
                    if (m_step == SHIFT_TICKS - 1) begin
                        m_step = 0;
                        m_pul  = 1'b1;
                        m_base = dr ? (m_base + 15) % 16 : (m_base + 1) % 16;
                        pul_q.push_back(4'(m_base));
                    end else begin
                        m_step = m_step + 1;
                    end
                end
            end
            m_an  = ~(8'b1 << m_idx);
            m_val = mem[(m_base + m_idx) % 16];
        end
        case (m_st)
            2'd0:    if (!sp && sa) m_st = 2'd1;
            2'd1:    if (sp) m_st = 2'd0; else if (hd) m_st = 2'd2;
            default: if (sp) m_st = 2'd0; else if (!hd) m_st = 2'd1;
        endcase
        m_cnt = tk ? 0 : m_cnt + 1;
        if (chk) push_exp();
    endtask

    task automatic run(input int n);
        repeat (n) clk1(1'b1);
    endtask

    task automatic to_cnt(input int c);
        while (m_cnt != c) clk1(1'b1);
    endtask

    // slot that will be displayed after the coming tick edge
    function automatic logic [3:0] next_slot();
        int ni, nb;
        ni = (m_idx + 1) % 8;
        nb = m_base;
        if (m_st == 2'd1 && m_step == SHIFT_TICKS - 1)
            nb = dir ? (nb + 15) % 16 : (nb + 1) % 16;
        return 4'((nb + ni) % 16);
    endfunction

    task automatic async_reset();
        clk1(1'b0);
        rst = 1'b1;
        model_reset();
        push_exp();
        repeat (2) begin @(posedge CLK); #1; push_exp(); end
        rst = 1'b0;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t       e;
        logic [3:0] pb;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (state !== e.st || base !== e.bs || digit_idx !== e.ix || anode !== e.an ||
                digit_val !== e.vl || shift_pulse !== e.pl) begin
                n_bad++;
                $display("FAIL snap ph%0d t=%0t: got st=%0d base=%0d idx=%0d anode=%h val=%h pulse=%b, want st=%0d base=%0d idx=%0d anode=%h val=%h pulse=%b",
                         e.ph, $time, state, base, digit_idx, anode, digit_val, shift_pulse,
                         e.st, e.bs, e.ix, e.an, e.vl, e.pl);
            end
        end
        if (shift_pulse === 1'b1) begin
            n_vec++;
            if (pul_q.size() == 0) begin
                n_bad++;
                $display("FAIL pulse t=%0t: got shift_pulse with base=%0d, want no pulse", $time, base);
            end else begin
                pb = pul_q.pop_front();
                if (base !== pb) begin
                    n_bad++;
                    $display("FAIL pulse_base t=%0t: got base=%0d, want %0d", $time, base, pb);
                end
            end
        end
        if (drain && !drained) begin
            drained = 1'b1;
            n_vec++;
            if (pul_q.size() != 0 || exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: got %0d steps and %0d snapshots outstanding, want 0",
                         pul_q.size(), exp_q.size());
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; dir = 1'b0;
        wr_en = 1'b0; wr_addr = 4'h0; wr_data = 4'h0;
        model_reset();
        repeat (2) begin @(posedge CLK); #1; push_exp(); end
        rst = 1'b0;

        // idle after reset: blanked, no steps, ticks have no effect
        phase = 1; run(6);

        // fill message with slot numbers while idle
        phase = 2;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i); clk1(1'b1);
        end
        wr_en = 1'b0;

        // scroll left long enough for base to wrap 15 -> 0
        phase = 3; start = 1'b1; clk1(1'b1); start = 1'b0; run(4 * 35);

        // pause with the step count at 1, then resume: step after one more tick
        phase = 4; to_cnt(0);
        if (m_step != 1) run(4);
        hold = 1'b1; clk1(1'b1); run(4 * 10); hold = 1'b0; run(12);

        // write-first on a plain edge and on a tick edge, then tag slot 0
        phase = 5; to_cnt(0);
        wr_en = 1'b1; wr_addr = 4'((m_base + m_idx) % 16); wr_data = 4'hA; clk1(1'b1);
        wr_en = 1'b0;
        to_cnt(CLK_DIV - 1);
        wr_en = 1'b1; wr_addr = next_slot(); wr_data = 4'h5; clk1(1'b1);
        wr_addr = 4'h0; wr_data = 4'h9; clk1(1'b1);
        wr_en = 1'b0;

        // direction change mid-run applies at the next step
        phase = 6; dir = 1'b1; run(20); dir = 1'b0; run(6);

        // stop and hold together: stop wins
        phase = 7; stop = 1'b1; hold = 1'b1; clk1(1'b1); stop = 1'b0; hold = 1'b0; run(5);

        // start+hold from idle: RUN then PAUSE; scroll right from base 0, slot 0 retained
        phase = 8; dir = 1'b1; start = 1'b1; hold = 1'b1; clk1(1'b1);
        start = 1'b0; clk1(1'b1); hold = 1'b0; run(24);

        // asynchronous reset mid-run clears everything including the buffer
        phase = 9; run(5); async_reset();
        phase = 10; dir = 1'b0; start = 1'b1; clk1(1'b1); start = 1'b0; run(24);

        drain = 1'b1;
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
